// File: rtl/gs_div_arbiter_pkg.sv
// Shared definitions for the divider arbiter: FSM encoding, divider flag
// bit positions and the quiet-NaN pattern returned on a watchdog abort.
package gs_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int FLG_W     = 5;
  localparam int FLG_NAN   = 4;
  localparam int FLG_NINF  = 3;
  localparam int FLG_PINF  = 2;
  localparam int FLG_PZERO = 1;
  localparam int FLG_NZERO = 0;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Flag vector reported when the divider never answers: only NaN is set.
  function automatic logic [FLG_W-1:0] timeout_flags();
    logic [FLG_W-1:0] f;
    f = '0;
    f[FLG_NAN] = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/gs_div_arbiter_if.sv
// Bundle of the client request, response and divider-side signals.
// Handshake rule for req_* and rsp_*: a transfer happens on a rising clk edge
// where valid and ready are both high; a valid source holds valid and its
// payload stable until that transfer. div_start/div_done are single-cycle
// pulses with no back-pressure.
interface gs_div_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  import gs_div_pkg::*;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_num;
  logic [NUM_REQ*32-1:0] req_den;
  logic [NUM_REQ-1:0]    req_ready;

  logic                  div_start;
  logic [31:0]           div_num;
  logic [31:0]           div_den;
  logic                  div_done;
  logic [31:0]           div_result;
  logic [FLG_W-1:0]      div_flags;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;
  logic [FLG_W-1:0]      rsp_flags;
  logic                  rsp_timeout;

  // Arbiter side.
  modport slave (
    input  req_valid, req_num, req_den, div_done, div_result, div_flags, rsp_ready,
    output req_ready, div_start, div_num, div_den, rsp_valid, rsp_id, rsp_result,
           rsp_flags, rsp_timeout
  );

  // Environment side: clients, divider core and response consumer.
  modport master (
    output req_valid, req_num, req_den, div_done, div_result, div_flags, rsp_ready,
    input  req_ready, div_start, div_num, div_den, rsp_valid, rsp_id, rsp_result,
           rsp_flags, rsp_timeout
  );

endinterface

// File: rtl/gs_div_arbiter_picker.sv
// Combinational round-robin picker: the first valid requester strictly after
// last_grant (wrapping) wins, so the most recent winner has lowest priority.
module gs_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic               any,
  output logic [ID_W-1:0]    grant_idx
);

  // Scan the NUM_REQ positions after last_grant and keep the first hit.
  always_comb begin
    logic [ID_W-1:0] idx;
    any       = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!any && req_valid[idx]) begin
        any       = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/gs_div_arbiter.sv
// Shares one start/done divider among NUM_REQ clients: round-robin grant,
// operand capture, launch pulse, watchdog and a single back-pressured
// response channel tagged with the requester ID.
module gs_div_arbiter
  import gs_div_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rstb,
  gs_div_arbiter_if.slave   bus,
  output logic              busy,
  output state_e            dbg_state
);

  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  state_e          state;
  state_e          state_nxt;
  logic [ID_W-1:0] last_grant;
  logic            pick_any;
  logic [ID_W-1:0] pick_idx;
  logic [TMR_W-1:0] timer;
  logic            timer_hit;

  gs_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_valid  (bus.req_valid),
    .last_grant (last_grant),
    .any        (pick_any),
    .grant_idx  (pick_idx)
  );

  // Abort point: the last WAIT cycle in which a done pulse is still accepted.
  assign timer_hit = (timer == TMR_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; done beats the watchdog when both land together.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.div_done || timer_hit) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs plus the one-hot accept, which only exists in IDLE and is
  // gated by rstb so it is low while reset is held.
  always_comb begin
    bus.req_ready = '0;
    if (rstb && state == IDLE && pick_any)
      bus.req_ready = NUM_REQ'(1) << pick_idx;
  end

  assign bus.div_start = (state == ISSUE);
  assign bus.rsp_valid = (state == RESP);
  assign busy          = (state != IDLE);
  assign dbg_state     = state;

  // Capture the winner's operands and ID at grant; remember the winner once
  // its response has been accepted.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      bus.div_num <= '0;
      bus.div_den <= '0;
      bus.rsp_id  <= '0;
      last_grant  <= ID_W'(NUM_REQ - 1);
    end else begin
      if (state == IDLE && pick_any) begin
        bus.div_num <= bus.req_num[32*pick_idx +: 32];
        bus.div_den <= bus.req_den[32*pick_idx +: 32];
        bus.rsp_id  <= pick_idx;
      end
      if (state == RESP && bus.rsp_ready)
        last_grant <= bus.rsp_id;
    end
  end

  // Watchdog: cleared on launch, counts in WAIT and holds at the abort value.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)
      timer <= '0;
    else if (state == ISSUE)
      timer <= '0;
    else if (state == WAIT && !timer_hit)
      timer <= timer + TMR_W'(1);
  end

  // Response payload: divider result on done, canned NaN on abort. Pulses on
  // div_done outside WAIT never reach these registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      bus.rsp_result  <= '0;
      bus.rsp_flags   <= '0;
      bus.rsp_timeout <= 1'b0;
    end else if (state == WAIT) begin
      if (bus.div_done) begin
        bus.rsp_result  <= bus.div_result;
        bus.rsp_flags   <= bus.div_flags;
        bus.rsp_timeout <= 1'b0;
      end else if (timer_hit) begin
        bus.rsp_result  <= QNAN;
        bus.rsp_flags   <= timeout_flags();
        bus.rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gs_div_arbiter.sv
// Bench for gs_div_arbiter: divider behavioural model, timeline reference
// model checked every cycle, directed scenarios and a randomized soak.
module tb_gs_div_arbiter;
  import gs_div_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic   clk  = 1'b0;
  logic   rstb = 1'b0;
  logic   busy;
  state_e dbg_state;

  always #5 clk = ~clk;

  gs_div_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  gs_div_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- divider model ----------------
  int          dv_lat     = 3;
  bit          dv_hang    = 1'b0;
  bit          dv_rand    = 1'b0;
  int          stray_req  = 0;
  int          stray_ack  = 0;
  int          dv_cnt     = 0;
  int          dv_lat_now;
  bit          dv_hang_now;
  logic        dv_st;
  logic [31:0] dv_sn, dv_sd, dv_n, dv_d;

  function automatic logic [31:0] div_fn(input logic [31:0] n, input logic [31:0] d);
    if (n == 32'h3F80_0000 && d == 32'h3F00_0000) return 32'h4000_0000;
    return {n[15:0], d[15:0]} ^ 32'h1234_5678;
  endfunction

  function automatic logic [4:0] flg_fn(input logic [31:0] n, input logic [31:0] d);
    return n[4:0] ^ d[9:5];
  endfunction

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      dv_cnt         = 0;
      bus.div_done   = 1'b0;
      bus.div_result = '0;
      bus.div_flags  = '0;
    end else begin
      dv_st = bus.div_start;
      dv_sn = bus.div_num;
      dv_sd = bus.div_den;
      #1;
      bus.div_done = 1'b0;
      if (dv_st) begin
        dv_n = dv_sn;
        dv_d = dv_sd;
        dv_lat_now  = dv_rand ? $urandom_range(1, TIMEOUT + 2) : dv_lat;
        dv_hang_now = dv_rand ? ($urandom_range(0, 9) == 0) : dv_hang;
        dv_cnt = dv_hang_now ? 0 : dv_lat_now;
      end
      if (dv_cnt > 0) begin
        dv_cnt--;
        if (dv_cnt == 0) begin
          bus.div_done   = 1'b1;
          bus.div_result = div_fn(dv_n, dv_d);
          bus.div_flags  = flg_fn(dv_n, dv_d);
        end
      end else if (stray_req != stray_ack || (dv_rand && $urandom_range(0, 24) == 0)) begin
        stray_ack      = stray_req;
        bus.div_done   = 1'b1;
        bus.div_result = $urandom;
        bus.div_flags  = 5'($urandom_range(0, 31));
      end
    end
  end

  // ---------------- reference model + compare ----------------
  bit          m_act  = 1'b0;
  int          m_last = NUM_REQ - 1;
  int          m_gcyc, m_rcyc, m_id;
  logic [31:0] m_num, m_den, m_res;
  logic [4:0]  m_flg;
  logic        m_to;
  bit          prev_rv = 1'b0;

  int          g_q[$];
  int          gc_q[$];
  int          s_q[$];
  int          r_cyc_q[$];
  int          r_id_q[$];
  logic [31:0] r_res_q[$];
  logic [4:0]  r_flg_q[$];
  logic        r_to_q[$];

  function automatic int pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] e_ready;
    logic e_start, e_rv, e_busy;
    int g;
    cyc++;
    if (!rstb) begin
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_div_start", bus.div_start, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_busy", busy, 0);
      m_act   = 1'b0;
      m_last  = NUM_REQ - 1;
      prev_rv = 1'b0;
    end else begin
      e_ready = '0;
      e_start = 1'b0;
      e_rv    = 1'b0;
      e_busy  = m_act;
      if (!m_act) begin
        g = pick(bus.req_valid, m_last);
        if (g >= 0) begin
          e_ready = NUM_REQ'(1) << g;
          m_act   = 1'b1;
          m_gcyc  = cyc;
          m_id    = g;
          m_num   = bus.req_num[32*g +: 32];
          m_den   = bus.req_den[32*g +: 32];
          m_rcyc  = -1;
        end
      end else begin
        if (cyc == m_gcyc + 1) e_start = 1'b1;
        if (m_rcyc < 0 && cyc > m_gcyc + 1) begin
          if (bus.div_done) begin
            m_rcyc = cyc + 1;
            m_res  = bus.div_result;
            m_flg  = bus.div_flags;
            m_to   = 1'b0;
          end else if (cyc == m_gcyc + 1 + TIMEOUT) begin
            m_rcyc = cyc + 1;
            m_res  = 32'h7FC0_0000;
            m_flg  = 5'b10000;
            m_to   = 1'b1;
          end
        end
        if (m_rcyc >= 0 && cyc >= m_rcyc) begin
          e_rv = 1'b1;
          check("rsp_id", bus.rsp_id, m_id);
          check("rsp_result", bus.rsp_result, m_res);
          check("rsp_flags", bus.rsp_flags, m_flg);
          check("rsp_timeout", bus.rsp_timeout, m_to);
          if (bus.rsp_ready) begin
            m_act  = 1'b0;
            m_last = m_id;
          end
        end
      end
      check("req_ready", bus.req_ready, e_ready);
      check("div_start", bus.div_start, e_start);
      if (e_start) begin
        check("div_num", bus.div_num, m_num);
        check("div_den", bus.div_den, m_den);
      end
      check("rsp_valid", bus.rsp_valid, e_rv);
      check("busy", busy, e_busy);

      for (int i = 0; i < NUM_REQ; i++)
        if (bus.req_ready[i]) begin
          g_q.push_back(i);
          gc_q.push_back(cyc);
        end
      if (bus.div_start) s_q.push_back(cyc);
      if (bus.rsp_valid && !prev_rv) begin
        r_cyc_q.push_back(cyc);
        r_id_q.push_back(int'(bus.rsp_id));
        r_res_q.push_back(bus.rsp_result);
        r_flg_q.push_back(bus.rsp_flags);
        r_to_q.push_back(bus.rsp_timeout);
      end
      prev_rv = bus.rsp_valid;
    end
  end

  // ---------------- driver tasks ----------------
  bit refill = 1'b0;

  task automatic set_req(input int i, input logic [31:0] n, input logic [31:0] d);
    bus.req_num[32*i +: 32] = n;
    bus.req_den[32*i +: 32] = d;
    bus.req_valid[i]        = 1'b1;
  endtask

  task automatic tick();
    logic [NUM_REQ-1:0] xfer;
    @(posedge clk);
    xfer = bus.req_valid & bus.req_ready;
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (xfer[i]) begin
        if (refill) set_req(i, $urandom, $urandom);
        else        bus.req_valid[i] = 1'b0;
      end
  endtask

  task automatic wait_rsp(input int budget, input string name);
    int n = 0;
    while (!bus.rsp_valid && n < budget) begin
      tick();
      n++;
    end
    check(name, bus.rsp_valid, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((busy || |bus.req_valid) && n < budget) begin
      tick();
      n++;
    end
    check(name, {busy, |bus.req_valid}, 0);
  endtask

  task automatic clear_logs();
    g_q.delete(); gc_q.delete(); s_q.delete();
    r_cyc_q.delete(); r_id_q.delete(); r_res_q.delete(); r_flg_q.delete(); r_to_q.delete();
  endtask

  task automatic do_reset();
    tick();
    rstb = 1'b0;
    tick();
    tick();
    rstb = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  logic [ID_W-1:0] exp_q[$];
  logic [31:0]     n0, d0;

  initial begin
    bus.req_valid = '0;
    bus.req_num   = '0;
    bus.req_den   = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) tick();
    rstb = 1'b1;

    // 1: single request from client 2
    clear_logs();
    dv_lat = 6;
    bus.rsp_ready = 1'b1;
    set_req(2, 32'h3F80_0000, 32'h3F00_0000);
    wait_idle(60, "t1_done");
    check("t1_ngrant", g_q.size(), 1);
    check("t1_grant", g_q[0], 2);
    check("t1_start_lat", s_q[0] - gc_q[0], 1);
    check("t1_rsp_lat", r_cyc_q[0] - s_q[0], 7);
    check("t1_id", r_id_q[0], 2);
    check("t1_result", r_res_q[0], 32'h4000_0000);
    check("t1_timeout", r_to_q[0], 0);

    // 2: all clients continuously valid after a reset
    do_reset();
    clear_logs();
    dv_lat = 2;
    refill = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, $urandom, $urandom);
    for (int n = 0; n < 200 && g_q.size() < 5; n++) tick();
    refill = 1'b0;
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    check("t2_ngrant", g_q.size() >= 5, 1);
    for (int i = 0; i < 5; i++) check("t2_order", g_q[i], exp_q[i]);
    wait_idle(200, "t2_drain");

    // 3: back-pressure on the response channel
    dv_lat = 3;
    bus.rsp_ready = 1'b0;
    set_req(1, $urandom, $urandom);
    wait_rsp(40, "t3_rsp");
    set_req(3, $urandom, $urandom);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_valid", bus.rsp_valid, 1);
      check("t3_no_ready", bus.req_ready, 0);
      check("t3_busy", busy, 1);
    end
    bus.rsp_ready = 1'b1;
    wait_idle(60, "t3_drain");

    // 4: divider hangs, then a normal request
    clear_logs();
    dv_hang = 1'b1;
    set_req(1, $urandom, $urandom);
    wait_rsp(TIMEOUT + 10, "t4_rsp");
    wait_idle(20, "t4_idle");
    check("t4_result", r_res_q[0], 32'h7FC0_0000);
    check("t4_flags", r_flg_q[0], 5'b10000);
    check("t4_timeout", r_to_q[0], 1);
    check("t4_rsp_lat", r_cyc_q[0] - s_q[0], TIMEOUT + 1);
    dv_hang = 1'b0;
    dv_lat  = 4;
    n0 = $urandom;
    d0 = $urandom;
    set_req(0, n0, d0);
    wait_idle(40, "t4_next");
    check("t4_next_timeout", r_to_q[1], 0);
    check("t4_next_result", r_res_q[1], div_fn(n0, d0));

    // 5: stray done in IDLE and RESP, done on the abort cycle
    clear_logs();
    stray_req++;
    repeat (3) tick();
    check("t5_idle_busy", busy, 0);
    dv_lat = TIMEOUT;
    bus.rsp_ready = 1'b0;
    n0 = $urandom;
    d0 = $urandom;
    set_req(3, n0, d0);
    wait_rsp(TIMEOUT + 10, "t5_rsp");
    stray_req++;
    repeat (3) tick();
    bus.rsp_ready = 1'b1;
    wait_idle(20, "t5_idle");
    check("t5_timeout", r_to_q[0], 0);
    check("t5_result", r_res_q[0], div_fn(n0, d0));
    check("t5_rsp_lat", r_cyc_q[0] - s_q[0], TIMEOUT + 1);

    // 6: asynchronous reset while waiting on the divider
    clear_logs();
    dv_lat = 10;
    set_req(2, $urandom, $urandom);
    for (int n = 0; n < 20 && s_q.size() == 0; n++) tick();
    repeat (3) tick();
    #2;
    rstb = 1'b0;
    #1;
    check("t6_rst_ready", bus.req_ready, 0);
    check("t6_rst_start", bus.div_start, 0);
    check("t6_rst_num", bus.div_num, 0);
    check("t6_rst_den", bus.div_den, 0);
    check("t6_rst_valid", bus.rsp_valid, 0);
    check("t6_rst_id", bus.rsp_id, 0);
    check("t6_rst_result", bus.rsp_result, 0);
    check("t6_rst_flags", bus.rsp_flags, 0);
    check("t6_rst_timeout", bus.rsp_timeout, 0);
    check("t6_rst_busy", busy, 0);
    set_req(0, $urandom, $urandom);
    set_req(2, $urandom, $urandom);
    set_req(3, $urandom, $urandom);
    tick();
    tick();
    clear_logs();
    rstb = 1'b1;
    wait_idle(100, "t6_drain");
    check("t6_first", g_q[0], 0);
    check("t6_nrsp", r_cyc_q.size(), 3);

    // randomized soak
    dv_rand = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_REQ; i++)
        if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) set_req(i, $urandom, $urandom);
      tick();
    end
    dv_rand = 1'b0;
    dv_hang = 1'b0;
    dv_lat  = 3;
    bus.rsp_ready = 1'b1;
    wait_idle(300, "soak_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
